rf_wb_arbiter: RTL and testbench

Write-back controller for the 32×32 register file. Arbitrates the single register-file write port between the execute-stage writer (EX) and the load writer (LD). Presents one registered write per cycle. Keeps a busy scoreboard of destination registers reserved at issue and not yet written, so the issue stage can stall on read-after-write hazards.

---
 rtl/rf_pkg.sv | 24 ++
 rtl/rf_wb_arbiter_if.sv | 51 +++++
 rtl/rf_scoreboard.sv | 47 ++++
 rtl/rf_wb_arbiter.sv | 106 ++++++++++
 tb/tb_rf_wb_arbiter.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared widths, requester enum and write-port struct for the register-file write-back path
package rf_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  typedef enum logic {
    REQ_EX = 1'b0,
    REQ_LD = 1'b1
  } req_e;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } rg_wr_t;

  // The requester that must be favoured next time, given the one just granted.
  function automatic req_e other_req(input req_e r);
    return (r == REQ_EX) ? REQ_LD : REQ_EX;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rtl/rf_wb_arbiter_if.sv - write request, reservation, hazard-check and write-port signals of the write-back arbiter
interface rf_wb_arbiter_if;
  import rf_pkg::*;

  logic              ex_valid;
  logic              ex_ready;
  logic [ADDR_W-1:0] ex_addr;
  logic [DATA_W-1:0] ex_data;

  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;

  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;

  logic [ADDR_W-1:0] chk_addr1;
  logic [ADDR_W-1:0] chk_addr2;
  logic              chk_busy1;
  logic              chk_busy2;
  logic              byp_hit1;
  logic              byp_hit2;
  logic [DATA_W-1:0] byp_data1;
  logic [DATA_W-1:0] byp_data2;

  logic              rg_wrt_en;
  logic [ADDR_W-1:0] rg_wrt_addr;
  logic [DATA_W-1:0] rg_wrt_data;

  // Requesters / issue stage side
  modport master (
    output ex_valid, ex_addr, ex_data,
    output ld_valid, ld_addr, ld_data,
    output rsv_en, rsv_addr, chk_addr1, chk_addr2,
    input  ex_ready, ld_ready,
    input  chk_busy1, chk_busy2, byp_hit1, byp_hit2, byp_data1, byp_data2,
    input  rg_wrt_en, rg_wrt_addr, rg_wrt_data
  );

  // Arbiter side
  modport slave (
    input  ex_valid, ex_addr, ex_data,
    input  ld_valid, ld_addr, ld_data,
    input  rsv_en, rsv_addr, chk_addr1, chk_addr2,
    output ex_ready, ld_ready,
    output chk_busy1, chk_busy2, byp_hit1, byp_hit2, byp_data1, byp_data2,
    output rg_wrt_en, rg_wrt_addr, rg_wrt_data
  );

endinterface

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - busy vector of reserved-but-unwritten destinations with two hazard check ports
module rf_scoreboard
  import rf_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rsv_en_i,
  input  logic [ADDR_W-1:0] rsv_addr_i,
  input  logic              clr_en_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  input  logic [ADDR_W-1:0] chk_addr1_i,
  input  logic [ADDR_W-1:0] chk_addr2_i,
  input  logic              mask1_i,
  input  logic              mask2_i,
  output logic              chk_busy1_o,
  output logic              chk_busy2_o
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Clear first, then set, so a reservation landing on the retiring register survives; x0 never busy
  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) begin
      busy_d[clr_addr_i] = 1'b0;
    end
    if (rsv_en_i && (rsv_addr_i != '0)) begin
      busy_d[rsv_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Busy vector register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // A register being forwarded this cycle is not a hazard when the mask is driven
  assign chk_busy1_o = busy_q[chk_addr1_i] && !mask1_i;
  assign chk_busy2_o = busy_q[chk_addr2_i] && !mask2_i;

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - round-robin EX/LD write-port arbiter, registered write stage, bypass (RF_WB_BYPASS_EN)
module rf_wb_arbiter (
  input  logic           clk,
  input  logic           reset_n,
  rf_wb_arbiter_if.slave bus
);
  import rf_pkg::*;

  req_e   ptr_q;
  req_e   ptr_d;
  rg_wr_t wr_q;
  rg_wr_t wr_d;

  logic ex_ready_w;
  logic ld_ready_w;
  logic ex_go;
  logic ld_go;
  logic contention;
  logic byp_hit1_w;
  logic byp_hit2_w;
  logic chk_busy1_w;
  logic chk_busy2_w;

  assign contention = bus.ex_valid && bus.ld_valid;

  // Grant: a lone requester always wins; on contention the pointer decides
  always_comb begin
    ex_ready_w = bus.ex_valid && (!bus.ld_valid || (ptr_q == REQ_EX));
    ld_ready_w = bus.ld_valid && (!bus.ex_valid || (ptr_q == REQ_LD));
  end

  assign ex_go = bus.ex_valid && ex_ready_w;
  assign ld_go = bus.ld_valid && ld_ready_w;

  // Pointer moves to the loser, and only when both requesters competed
  always_comb begin
    ptr_d = ptr_q;
    if (contention) begin
      ptr_d = other_req(ptr_q);
    end
  end

  // Output stage: load the winning request; x0 is accepted but never enables the write
  always_comb begin
    wr_d    = wr_q;
    wr_d.en = 1'b0;
    if (ex_go) begin
      wr_d.addr = bus.ex_addr;
      wr_d.data = bus.ex_data;
      wr_d.en   = (bus.ex_addr != '0);
    end else if (ld_go) begin
      wr_d.addr = bus.ld_addr;
      wr_d.data = bus.ld_data;
      wr_d.en   = (bus.ld_addr != '0);
    end
  end

  // Pointer and write-port registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= REQ_EX;
      wr_q  <= '0;
    end else begin
      ptr_q <= ptr_d;
      wr_q  <= wr_d;
    end
  end

`ifdef RF_WB_BYPASS_EN
  assign byp_hit1_w    = wr_q.en && (wr_q.addr == bus.chk_addr1) && (bus.chk_addr1 != '0);
  assign byp_hit2_w    = wr_q.en && (wr_q.addr == bus.chk_addr2) && (bus.chk_addr2 != '0);
  assign bus.byp_data1 = wr_q.data;
  assign bus.byp_data2 = wr_q.data;
`else
  assign byp_hit1_w    = 1'b0;
  assign byp_hit2_w    = 1'b0;
  assign bus.byp_data1 = '0;
  assign bus.byp_data2 = '0;
`endif

  rf_scoreboard u_scoreboard (
    .clk         (clk),
    .reset_n     (reset_n),
    .rsv_en_i    (bus.rsv_en),
    .rsv_addr_i  (bus.rsv_addr),
    .clr_en_i    (wr_q.en),
    .clr_addr_i  (wr_q.addr),
    .chk_addr1_i (bus.chk_addr1),
    .chk_addr2_i (bus.chk_addr2),
    .mask1_i     (byp_hit1_w),
    .mask2_i     (byp_hit2_w),
    .chk_busy1_o (chk_busy1_w),
    .chk_busy2_o (chk_busy2_w)
  );

  assign bus.ex_ready    = ex_ready_w;
  assign bus.ld_ready    = ld_ready_w;
  assign bus.byp_hit1    = byp_hit1_w;
  assign bus.byp_hit2    = byp_hit2_w;
  assign bus.chk_busy1   = chk_busy1_w;
  assign bus.chk_busy2   = chk_busy2_w;
  assign bus.rg_wrt_en   = wr_q.en;
  assign bus.rg_wrt_addr = wr_q.addr;
  assign bus.rg_wrt_data = wr_q.data;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - scoreboard bench for rf_wb_arbiter (expectations follow RF_WB_BYPASS_EN)
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  logic clk;
  logic reset_n;

  rf_wb_arbiter_if bus ();

  rf_wb_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } exp_t;

  exp_t exp_q[$];

  logic              m_ptr;
  logic [31:0]       m_busy;
  logic              m_wen;
  logic [ADDR_W-1:0] m_waddr;
  logic [DATA_W-1:0] m_wdata;
  logic              last_ex_go;
  logic              last_ld_go;
  int                n_checks;
  int                n_fail;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.ex_valid  = 1'b0;
    bus.ex_addr   = '0;
    bus.ex_data   = '0;
    bus.ld_valid  = 1'b0;
    bus.ld_addr   = '0;
    bus.ld_data   = '0;
    bus.rsv_en    = 1'b0;
    bus.rsv_addr  = '0;
  endtask

  task automatic model_reset();
    m_ptr   = 1'b0;
    m_busy  = '0;
    m_wen   = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
    exp_q.delete();
  endtask

  // One clock: check combinational outputs, predict, cross the edge, check the write port
  task automatic tick();
    logic              ex_go, ld_go, h1, h2, cont, n_wen;
    logic [DATA_W-1:0] bd, n_wdata;
    logic [ADDR_W-1:0] n_waddr;
    logic [31:0]       nb;
    exp_t              e;
    #1;
    ex_go = bus.ex_valid && (!bus.ld_valid || (m_ptr == 1'b0));
    ld_go = bus.ld_valid && (!bus.ex_valid || (m_ptr == 1'b1));
    cont  = bus.ex_valid && bus.ld_valid;
    check_eq("ex_ready", 32'(bus.ex_ready), 32'(ex_go));
    check_eq("ld_ready", 32'(bus.ld_ready), 32'(ld_go));
`ifdef RF_WB_BYPASS_EN
    h1 = m_wen && (m_waddr == bus.chk_addr1) && (bus.chk_addr1 != '0);
    h2 = m_wen && (m_waddr == bus.chk_addr2) && (bus.chk_addr2 != '0);
    bd = m_wdata;
`else
    h1 = 1'b0;
    h2 = 1'b0;
    bd = '0;
`endif
    check_eq("byp_hit1", 32'(bus.byp_hit1), 32'(h1));
    check_eq("byp_hit2", 32'(bus.byp_hit2), 32'(h2));
    check_eq("byp_data1", bus.byp_data1, bd);
    check_eq("byp_data2", bus.byp_data2, bd);
    check_eq("chk_busy1", 32'(bus.chk_busy1), 32'(m_busy[bus.chk_addr1] && !h1));
    check_eq("chk_busy2", 32'(bus.chk_busy2), 32'(m_busy[bus.chk_addr2] && !h2));
    nb = m_busy;
    if (m_wen) nb[m_waddr] = 1'b0;
    if (bus.rsv_en && (bus.rsv_addr != '0)) nb[bus.rsv_addr] = 1'b1;
    nb[0] = 1'b0;
    n_wen   = 1'b0;
    n_waddr = m_waddr;
    n_wdata = m_wdata;
    if (ex_go) begin
      n_waddr = bus.ex_addr;
      n_wdata = bus.ex_data;
      n_wen   = (bus.ex_addr != '0);
    end else if (ld_go) begin
      n_waddr = bus.ld_addr;
      n_wdata = bus.ld_data;
      n_wen   = (bus.ld_addr != '0);
    end
    if (n_wen) exp_q.push_back('{a: n_waddr, d: n_wdata});
    last_ex_go = ex_go;
    last_ld_go = ld_go;
    @(posedge clk);
    #1;
    if (cont) m_ptr = ~m_ptr;
    m_busy  = nb;
    m_wen   = n_wen;
    m_waddr = n_waddr;
    m_wdata = n_wdata;
    check_eq("wr_en", 32'(bus.rg_wrt_en), 32'(m_wen));
    check_eq("wr_addr", 32'(bus.rg_wrt_addr), 32'(m_waddr));
    check_eq("wr_data", bus.rg_wrt_data, m_wdata);
    if (bus.rg_wrt_en) begin
      if (exp_q.size() == 0) begin
        check_eq("wr_unexpected", 32'(bus.rg_wrt_en), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("sb_addr", 32'(bus.rg_wrt_addr), 32'(e.a));
        check_eq("sb_data", bus.rg_wrt_data, e.d);
      end
    end
  endtask

  initial begin
    logic [DATA_W-1:0] ex_d, ld_d;
    n_checks = 0;
    n_fail   = 0;
    last_ex_go = 1'b0;
    last_ld_go = 1'b0;
    model_reset();
    idle_inputs();
    bus.chk_addr1 = '0;
    bus.chk_addr2 = '0;

    // Reset state
    reset_n = 1'b0;
    #1;
    check_eq("rst_wr_en", 32'(bus.rg_wrt_en), 32'd0);
    check_eq("rst_wr_addr", 32'(bus.rg_wrt_addr), 32'd0);
    check_eq("rst_wr_data", bus.rg_wrt_data, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Contention: EX, LD, EX, LD with the loser holding its request
    ex_d = 32'hE000_0000;
    ld_d = 32'hD000_0000;
    for (int i = 0; i < 4; i++) begin
      bus.ex_valid = 1'b1; bus.ex_addr = 5'd3; bus.ex_data = ex_d;
      bus.ld_valid = 1'b1; bus.ld_addr = 5'd7; bus.ld_data = ld_d;
      #1;
      check_eq("cont_ex_ready", 32'(bus.ex_ready), 32'((i % 2) == 0));
      check_eq("cont_ld_ready", 32'(bus.ld_ready), 32'((i % 2) == 1));
      tick();
      if (last_ex_go) ex_d = ex_d + 1;
      if (last_ld_go) ld_d = ld_d + 1;
    end
    idle_inputs();
    tick();
    tick();
    check_eq("cont_drain", 32'(exp_q.size()), 32'd0);

    // Single requester
    bus.ex_valid = 1'b1; bus.ex_addr = 5'd5; bus.ex_data = 32'hDEADBEEF;
    #1;
    check_eq("single_ex_ready", 32'(bus.ex_ready), 32'd1);
    tick();
    idle_inputs();
    check_eq("single_wr_en", 32'(bus.rg_wrt_en), 32'd1);
    check_eq("single_wr_data", bus.rg_wrt_data, 32'hDEADBEEF);
    tick();
    check_eq("single_wr_en_drop", 32'(bus.rg_wrt_en), 32'd0);

    // Write to x0
    bus.chk_addr1 = 5'd0;
    bus.ld_valid = 1'b1; bus.ld_addr = 5'd0; bus.ld_data = 32'h1234;
    #1;
    check_eq("x0_ld_ready", 32'(bus.ld_ready), 32'd1);
    tick();
    idle_inputs();
    check_eq("x0_wr_en", 32'(bus.rg_wrt_en), 32'd0);
    tick();

    // Scoreboard reserve, bypass in the write cycle, set beats clear, then retire
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd9;
    tick();
    idle_inputs();
    bus.chk_addr1 = 5'd9;
    bus.chk_addr2 = 5'd9;
    #1;
    check_eq("sb_busy1_set", 32'(bus.chk_busy1), 32'd1);
    tick();
    bus.ex_valid = 1'b1; bus.ex_addr = 5'd9; bus.ex_data = 32'hA5A5A5A5;
    tick();
    idle_inputs();
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd9;
    #1;
`ifdef RF_WB_BYPASS_EN
    check_eq("byp_hit2_wr", 32'(bus.byp_hit2), 32'd1);
    check_eq("byp_data2_wr", bus.byp_data2, 32'hA5A5A5A5);
    check_eq("byp_busy2_wr", 32'(bus.chk_busy2), 32'd0);
`else
    check_eq("byp_hit2_wr", 32'(bus.byp_hit2), 32'd0);
    check_eq("byp_busy2_wr", 32'(bus.chk_busy2), 32'd1);
`endif
    tick();
    idle_inputs();
    #1;
    check_eq("sb_set_wins", 32'(bus.chk_busy1), 32'd1);
    bus.ex_valid = 1'b1; bus.ex_addr = 5'd9; bus.ex_data = 32'h0000_0011;
    tick();
    idle_inputs();
    tick();
    check_eq("sb_retired", 32'(bus.chk_busy1), 32'd0);

    // Reset in the middle of a transfer
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd12;
    tick();
    idle_inputs();
    bus.ex_valid = 1'b1; bus.ex_addr = 5'd12; bus.ex_data = 32'hCAFE0012;
    bus.chk_addr1 = 5'd12;
    tick();
    idle_inputs();
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_wr_en", 32'(bus.rg_wrt_en), 32'd0);
    check_eq("mid_rst_wr_addr", 32'(bus.rg_wrt_addr), 32'd0);
    check_eq("mid_rst_wr_data", bus.rg_wrt_data, 32'd0);
    check_eq("mid_rst_busy", 32'(bus.chk_busy1), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    bus.ex_valid = 1'b1; bus.ex_addr = 5'd3; bus.ex_data = 32'h3333_0000;
    bus.ld_valid = 1'b1; bus.ld_addr = 5'd7; bus.ld_data = 32'h7777_0000;
    #1;
    check_eq("post_rst_ex_first", 32'(bus.ex_ready), 32'd1);
    tick();
    bus.ex_valid = 1'b0;
    tick();
    idle_inputs();
    tick();

    // Random traffic, requesters hold while stalled
    for (int c = 0; c < 300; c++) begin
      if (!(bus.ex_valid && !last_ex_go)) begin
        bus.ex_valid = 1'($urandom_range(0, 1));
        bus.ex_addr  = 5'($urandom_range(0, 31));
        bus.ex_data  = $urandom;
      end
      if (!(bus.ld_valid && !last_ld_go)) begin
        bus.ld_valid = 1'($urandom_range(0, 1));
        bus.ld_addr  = 5'($urandom_range(0, 31));
        bus.ld_data  = $urandom;
      end
      bus.rsv_en    = 1'($urandom_range(0, 1));
      bus.rsv_addr  = 5'($urandom_range(0, 31));
      bus.chk_addr1 = 5'($urandom_range(0, 31));
      bus.chk_addr2 = 5'($urandom_range(0, 31));
      tick();
    end
    while (bus.ex_valid && !last_ex_go) tick();
    idle_inputs();
    tick();
    tick();
    check_eq("final_drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
